// File: rtl/maxpool2_stream_pkg.sv
// Shared float32 field layout and sizing helpers for the max-pooling stage.
package maxpool2_stream_pkg;

    localparam int F32_W    = 32;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;
    localparam int MANT_LSB = 0;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/maxpool2_stream_if.sv
// Pixel stream in, pooled stream out, plus stage enable and restart control.
interface maxpool2_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  pool_enable;
    logic                  start;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  frame_done;
    logic                  layer_done;

    modport master (
        output pool_enable, start, data_in, data_in_valid,
        input  data_out, data_out_valid, frame_done, layer_done
    );

    modport slave (
        input  pool_enable, start, data_in, data_in_valid,
        output data_out, data_out_valid, frame_done, layer_done
    );
endinterface

// File: rtl/maxpool2_stream_float_max.sv
// Combinational float32 max under a total order of bit patterns; equal keys return a.
// Negative values map to ~bits and positive to sign-flipped bits, so +0 beats -0.
module float_max
    import maxpool2_stream_pkg::*;
(
    input  logic [F32_W-1:0] i_a,
    input  logic [F32_W-1:0] i_b,
    output logic [F32_W-1:0] o_max
);
    logic [F32_W-1:0] w_key_a;
    logic [F32_W-1:0] w_key_b;

    always_comb begin
        w_key_a = i_a[SIGN_BIT] ? ~i_a
                                : {~i_a[SIGN_BIT], i_a[EXP_MSB:EXP_LSB], i_a[MANT_MSB:MANT_LSB]};
        w_key_b = i_b[SIGN_BIT] ? ~i_b
                                : {~i_b[SIGN_BIT], i_b[EXP_MSB:EXP_LSB], i_b[MANT_MSB:MANT_LSB]};
        o_max   = (w_key_b > w_key_a) ? i_b : i_a;
    end
endmodule

// File: rtl/maxpool2_stream.sv
// Streaming 2x2/stride-2 float32 max pool; output strobe 1 cycle after the odd-row/odd-col pixel.
// No backpressure: pixels are taken whenever enabled and valid, with arbitrary gaps.
module maxpool2_stream
    import maxpool2_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IFM_SIZE   = 28,
    parameter int IFM_DEPTH  = 6
) (
    input logic              clk,
    input logic              reset,
    maxpool2_stream_if.slave s
);
    localparam int OFM_SIZE = IFM_SIZE / 2;
    localparam int COL_W    = cnt_w(IFM_SIZE);
    localparam int CH_W     = cnt_w(IFM_DEPTH);
    localparam int IDX_W    = cnt_w(OFM_SIZE);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IFM_SIZE - 1);
    localparam logic [COL_W-1:0] POOL_LAST = COL_W'(2 * OFM_SIZE - 1);
    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(IFM_DEPTH - 1);

    logic [COL_W-1:0]      r_col;
    logic [COL_W-1:0]      r_row;
    logic [CH_W-1:0]       r_chan;
    logic [DATA_WIDTH-1:0] r_pair;
    logic [DATA_WIDTH-1:0] r_linebuf [OFM_SIZE];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_out_valid;
    logic                  r_frame_done;
    logic                  r_layer_done;

    logic                  w_accept;
    logic                  w_pool;
    logic                  w_emit;
    logic                  w_write;
    logic                  w_frame_last;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_pair_max;
    logic [DATA_WIDTH-1:0] w_win_max;

    // A restart drops any pixel presented in the same cycle.
    assign w_accept     = s.pool_enable && s.data_in_valid && !s.start;
    // Trailing column/row of an odd-sized map never forms a full window.
    assign w_pool       = r_col[0] && (r_col <= POOL_LAST) && (r_row <= POOL_LAST);
    assign w_emit       = w_accept && w_pool && r_row[0];
    assign w_write      = w_accept && w_pool && !r_row[0];
    assign w_frame_last = (r_row == POOL_LAST) && (r_col == POOL_LAST);
    assign w_idx        = IDX_W'(r_col >> 1);

    float_max u_pair_max (
        .i_a   (r_pair),
        .i_b   (s.data_in),
        .o_max (w_pair_max)
    );

    float_max u_row_max (
        .i_a   (r_linebuf[w_idx]),
        .i_b   (w_pair_max),
        .o_max (w_win_max)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col            <= '0;
            r_row            <= '0;
            r_chan           <= '0;
            r_pair           <= '0;
            r_data_out       <= '0;
            r_data_out_valid <= 1'b0;
            r_frame_done     <= 1'b0;
            r_layer_done     <= 1'b0;
        end else begin
            r_data_out_valid <= 1'b0;
            r_frame_done     <= 1'b0;
            r_layer_done     <= 1'b0;
            if (s.start) begin
                r_col  <= '0;
                r_row  <= '0;
                r_chan <= '0;
            end else if (w_accept) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    if (r_row == COL_LAST) begin
                        r_row  <= '0;
                        r_chan <= (r_chan == CH_LAST) ? '0 : r_chan + CH_W'(1);
                    end else begin
                        r_row <= r_row + COL_W'(1);
                    end
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
                if (!r_col[0]) begin
                    r_pair <= s.data_in;
                end
                if (w_emit) begin
                    r_data_out       <= w_win_max;
                    r_data_out_valid <= 1'b1;
                    r_frame_done     <= w_frame_last;
                    r_layer_done     <= w_frame_last && (r_chan == CH_LAST);
                end
            end
        end
    end

    // Line buffer holds the even-row pair maxima; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_linebuf[w_idx] <= w_pair_max;
        end
    end

    assign s.data_out       = r_data_out;
    assign s.data_out_valid = r_data_out_valid;
    assign s.frame_done     = r_frame_done;
    assign s.layer_done     = r_layer_done;
endmodule

// File: tb/tb_maxpool2_stream.sv
// Directed bench: 4x4/depth1, 5x5/depth1 and 4x4/depth3 instances share one driven stream, gated by sel.
module tb_maxpool2_stream;
    import maxpool2_stream_pkg::*;

    typedef struct {
        logic [31:0] pix;
        logic        ev;
        logic [31:0] ed;
        logic        efd;
        logic        eld;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        fd;
        logic        ld;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] d_pix;
    logic        d_vld, d_en, d_start;
    int          sel;
    int          checks = 0;
    int          failures = 0;
    vec_t        tbl[$];
    out_t        cq[$];

    maxpool2_stream_if #(.DATA_WIDTH(32)) ifa ();
    maxpool2_stream_if #(.DATA_WIDTH(32)) ifb ();
    maxpool2_stream_if #(.DATA_WIDTH(32)) ifc ();

    assign ifa.data_in = d_pix;  assign ifa.pool_enable = d_en;
    assign ifb.data_in = d_pix;  assign ifb.pool_enable = d_en;
    assign ifc.data_in = d_pix;  assign ifc.pool_enable = d_en;
    assign ifa.data_in_valid = d_vld && (sel == 0);
    assign ifb.data_in_valid = d_vld && (sel == 1);
    assign ifc.data_in_valid = d_vld && (sel == 2);
    assign ifa.start = d_start && (sel == 0);
    assign ifb.start = d_start && (sel == 1);
    assign ifc.start = d_start && (sel == 2);

    maxpool2_stream #(.DATA_WIDTH(32), .IFM_SIZE(4), .IFM_DEPTH(1)) u_a (.clk(clk), .reset(reset), .s(ifa));
    maxpool2_stream #(.DATA_WIDTH(32), .IFM_SIZE(5), .IFM_DEPTH(1)) u_b (.clk(clk), .reset(reset), .s(ifb));
    maxpool2_stream #(.DATA_WIDTH(32), .IFM_SIZE(4), .IFM_DEPTH(3)) u_c (.clk(clk), .reset(reset), .s(ifc));

    logic [31:0] o_dat;
    logic        o_vld, o_fd, o_ld;
    always_comb begin
        o_dat = ifa.data_out;  o_vld = ifa.data_out_valid;
        o_fd  = ifa.frame_done; o_ld = ifa.layer_done;
        if (sel == 1) begin
            o_dat = ifb.data_out;  o_vld = ifb.data_out_valid;
            o_fd  = ifb.frame_done; o_ld = ifb.layer_done;
        end else if (sel == 2) begin
            o_dat = ifc.data_out;  o_vld = ifc.data_out_valid;
            o_fd  = ifc.frame_done; o_ld = ifc.layer_done;
        end
    end

    always @(negedge clk) begin
        if (ifc.data_out_valid) cq.push_back('{ifc.data_out, ifc.frame_done, ifc.layer_done});
    end

    // Exact float32 encoding of a small non-negative integer.
    function automatic logic [31:0] f32(input int n);
        int e;
        if (n == 0) return 32'h0;
        e = 0;
        while ((1 << (e + 1)) <= n) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] pix, input logic vld, input logic en, input logic st);
        @(negedge clk);
        d_pix = pix; d_vld = vld; d_en = en; d_start = st;
        @(posedge clk);
        #1;
        d_vld = 1'b0; d_start = 1'b0;
    endtask

    task automatic add(input logic [31:0] pix, input logic ev, input logic [31:0] ed,
                       input logic efd, input logic eld);
        tbl.push_back('{pix, ev, ed, efd, eld});
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            cyc(tbl[i].pix, 1'b1, 1'b1, 1'b0);
            chkb($sformatf("%s[%0d].vld", tag, i), o_vld, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("%s[%0d].dat", tag, i), o_dat, tbl[i].ed);
                chkb($sformatf("%s[%0d].fd", tag, i), o_fd, tbl[i].efd);
                chkb($sformatf("%s[%0d].ld", tag, i), o_ld, tbl[i].eld);
            end
        end
        tbl.delete();
    endtask

    task automatic load_frame4();
        logic [31:0] e4 [4];
        int k;
        e4 = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
        k = 0;
        for (int n = 1; n <= 16; n++) begin
            if (n == 6 || n == 8 || n == 14 || n == 16) begin
                add(f32(n), 1'b1, e4[k], k == 3, k == 3);
                k++;
            end else begin
                add(f32(n), 1'b0, 32'h0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        int exp_c [12];
        reset = 1'b0; sel = 0;
        d_pix = '0; d_vld = 1'b0; d_en = 1'b1; d_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chkb("rst.vld", o_vld, 1'b0);
        chk("rst.dat", o_dat, 32'h0);
        chkb("rst.fd", o_fd, 1'b0);
        chkb("rst.ld", o_ld, 1'b0);
        @(negedge clk) reset = 1'b1;

        // Ramp 1..16 on 4x4
        load_frame4();
        run_table("t1");

        // Signed values and zero ordering
        add(32'hC0400000, 0, 0, 0, 0); add(32'hBF800000, 0, 0, 0, 0);
        add(32'h00000000, 0, 0, 0, 0); add(32'h80000000, 0, 0, 0, 0);
        add(32'hC0000000, 0, 0, 0, 0); add(32'h80000000, 1, 32'h80000000, 0, 0);
        add(32'hC0A00000, 0, 0, 0, 0); add(32'hC0E00000, 1, 32'h00000000, 0, 0);
        for (int n = 1; n <= 8; n++)
            add(f32(n), n == 6 || n == 8, (n == 6) ? 32'h40C00000 : 32'h41000000, n == 8, n == 8);
        run_table("t2");

        // Odd 5x5 map, then the next channel restarts at row 0
        sel = 1;
        for (int n = 1; n <= 25; n++) begin
            case (n)
                7:       add(f32(n), 1, 32'h40E00000, 0, 0);
                9:       add(f32(n), 1, 32'h41100000, 0, 0);
                17:      add(f32(n), 1, 32'h41880000, 0, 0);
                19:      add(f32(n), 1, 32'h41980000, 1, 1);
                default: add(f32(n), 0, 0, 0, 0);
            endcase
        end
        for (int n = 1; n <= 7; n++)
            add(f32(n), n == 7, 32'h40E00000, 1'b0, 1'b0);
        run_table("t3");

        // Reset mid-frame after 9 pixels
        sel = 0;
        for (int n = 1; n <= 9; n++)
            add(f32(n), n == 6 || n == 8, (n == 6) ? 32'h40C00000 : 32'h41000000, 1'b0, 1'b0);
        run_table("t5pre");
        @(negedge clk);
        reset = 1'b0; d_pix = f32(10); d_vld = 1'b1;
        #1;
        chk("t5.rst_dat", o_dat, 32'h0);
        chkb("t5.rst_vld", o_vld, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t5.rst_dat2", o_dat, 32'h0);
        chkb("t5.rst_vld2", o_vld, 1'b0);
        chkb("t5.rst_fd", o_fd, 1'b0);
        @(negedge clk);
        d_vld = 1'b0; reset = 1'b1;
        load_frame4();
        run_table("t5");

        // start with a coincident pixel mid-frame
        for (int n = 1; n <= 5; n++) add(f32(n), 0, 0, 0, 0);
        run_table("t6pre");
        cyc(f32(100), 1'b1, 1'b1, 1'b1);
        chkb("t6.start_vld", o_vld, 1'b0);
        load_frame4();
        run_table("t6");

        // Depth 3 with gaps and an enable drop, compared against hand-pooled frames
        sel = 2;
        exp_c = '{6, 8, 14, 16, 22, 24, 30, 32, 48, 46, 40, 38};
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 16; i++) begin
                repeat ($urandom_range(0, 5)) cyc(f32(99), 1'b0, 1'b1, 1'b0);
                if (c == 1 && i == 2) repeat (4) cyc(f32(99), 1'b1, 1'b0, 1'b0);
                cyc(f32((c < 2) ? (1 + i + 16 * c) : (48 - i)), 1'b1, 1'b1, 1'b0);
            end
        end
        repeat (3) @(posedge clk);
        chk("t4.count", 32'(cq.size()), 32'd12);
        for (int j = 0; j < 12 && j < cq.size(); j++) begin
            chk($sformatf("t4[%0d].dat", j), cq[j].dat, f32(exp_c[j]));
            chkb($sformatf("t4[%0d].fd", j), cq[j].fd, (j % 4) == 3);
            chkb($sformatf("t4[%0d].ld", j), cq[j].ld, j == 11);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
